bist_scheduler: RTL and testbench

//  Runs up to NUM_ENG BIST engine controllers one after another on a shared test resource.

---
 rtl/bist_scheduler.sv | 138 +++++++++++++
 tb/tb_bist_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_scheduler.sv
// Sequential BIST scheduler: launches enabled engines one at a time on a shared
// test resource, watchdogs each run and records pass/timeout per engine.
module bist_scheduler #(
    parameter int  NUM_ENG   = 4,
    parameter int  TIMEOUT   = 1023,
    parameter int  START_LEN = 2,
    localparam int IDXW      = $clog2(NUM_ENG)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sched_start,
    input  logic               abort,
    input  logic [NUM_ENG-1:0] eng_mask,
    input  logic [NUM_ENG-1:0] eng_finish,
    output logic [NUM_ENG-1:0] eng_bist_start,
    output logic [IDXW-1:0]    cur_eng,
    output logic               busy,
    output logic               sched_done,
    output logic [NUM_ENG-1:0] pass_flags,
    output logic [NUM_ENG-1:0] timeout_flags
);
    localparam int              WDW      = $clog2(TIMEOUT + 1);
    localparam int              SCW      = $clog2(START_LEN + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ENG - 1);
    localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT);
    localparam logic [SCW-1:0]  ST_LAST  = SCW'(START_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDXW-1:0]    idx;
    logic [WDW-1:0]     wdog;
    logic [SCW-1:0]     st_cnt;
    logic [NUM_ENG-1:0] mask_q;
    logic               prev_start;
    logic               launch;

    assign launch  = sched_start & ~prev_start;
    assign cur_eng = idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            wdog           <= '0;
            st_cnt         <= '0;
            mask_q         <= '0;
            prev_start     <= 1'b0;
            eng_bist_start <= '0;
            busy           <= 1'b0;
            sched_done     <= 1'b0;
            pass_flags     <= '0;
            timeout_flags  <= '0;
        end else begin
            prev_start <= sched_start;
            sched_done <= 1'b0;
            // Abort drops everything but the flags already recorded.
            if (abort && state != S_IDLE) begin
                state          <= S_IDLE;
                eng_bist_start <= '0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (launch) begin
                            mask_q        <= eng_mask;
                            idx           <= '0;
                            pass_flags    <= '0;
                            timeout_flags <= '0;
                            busy          <= 1'b1;
                            state         <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        if (mask_q[idx]) begin
                            st_cnt         <= '0;
                            eng_bist_start <= NUM_ENG'(1) << idx;
                            state          <= S_START;
                        end else if (idx == LAST_IDX) begin
                            sched_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                    S_START: begin
                        if (st_cnt == ST_LAST) begin
                            eng_bist_start <= '0;
                            wdog           <= '0;
                            state          <= S_WAIT;
                        end else begin
                            st_cnt <= st_cnt + SCW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (wdog != WD_MAX)
                            wdog <= wdog + WDW'(1);
                        // A finish in the final watchdog cycle still counts as a pass.
                        if (eng_finish[idx]) begin
                            pass_flags[idx] <= 1'b1;
                            state           <= S_NEXT;
                        end else if (wdog == WD_LAST) begin
                            timeout_flags[idx] <= 1'b1;
                            state              <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (idx == LAST_IDX) begin
                            sched_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            idx   <= idx + IDXW'(1);
                            state <= S_SELECT;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        eng_bist_start <= '0;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_scheduler.sv
// Bench for bist_scheduler: timeline model of the schedule, engine responders
// with programmable finish delay, and directed scenarios with literal checks.
module tb_bist_scheduler;
    localparam int NE = 4;
    localparam int TO = 16;
    localparam int SL = 2;

    logic          clock = 1'b0;
    logic          reset, sched_start, abort;
    logic [NE-1:0] eng_mask, eng_finish, eng_bist_start, pass_flags, timeout_flags;
    logic [1:0]    cur_eng;
    logic          busy, sched_done;

    bist_scheduler #(.NUM_ENG(NE), .TIMEOUT(TO), .START_LEN(SL)) dut (
        .clock(clock), .reset(reset), .sched_start(sched_start), .abort(abort),
        .eng_mask(eng_mask), .eng_finish(eng_finish), .eng_bist_start(eng_bist_start),
        .cur_eng(cur_eng), .busy(busy), .sched_done(sched_done),
        .pass_flags(pass_flags), .timeout_flags(timeout_flags)
    );

    always #5 clock = ~clock;

    // ---------------- timeline model ----------------
    logic [NE-1:0] e_start, e_pass, e_to;
    logic [1:0]    e_cur;
    logic          e_busy, e_done, m_prev, m_launch;

    task automatic m_tick(output bit kill);
        @(posedge clock);
        m_launch = sched_start && !m_prev && !reset;
        m_prev   = reset ? 1'b0 : sched_start;
        kill     = 1'b0;
        if (reset) begin
            e_start = '0; e_busy = 1'b0; e_done = 1'b0;
            e_pass = '0; e_to = '0; e_cur = '0; kill = 1'b1;
        end else if (abort && e_busy) begin
            e_start = '0; e_busy = 1'b0; e_done = 1'b0; kill = 1'b1;
        end
    endtask

    task automatic m_run();
        bit k;
        int w;
        logic [NE-1:0] mask;
        mask = eng_mask;
        e_pass = '0; e_to = '0; e_cur = '0; e_busy = 1'b1;
        for (int i = 0; i < NE; i++) begin
            m_tick(k); if (k) return;
            if (!mask[i]) begin
                if (i == NE - 1) break;
                e_cur = 2'(i + 1);
                continue;
            end
            e_start = 4'(1 << i);
            repeat (SL) begin m_tick(k); if (k) return; end
            e_start = '0;
            w = 0;
            forever begin
                m_tick(k); if (k) return;
                if (eng_finish[i]) begin e_pass[i] = 1'b1; break; end
                w++;
                if (w == TO) begin e_to[i] = 1'b1; break; end
            end
            m_tick(k); if (k) return;
            if (i < NE - 1) e_cur = 2'(i + 1);
        end
        e_done = 1'b1;
        m_tick(k);
        e_done = 1'b0;
        e_busy = 1'b0;
    endtask

    initial begin
        bit k;
        e_start = '0; e_pass = '0; e_to = '0; e_cur = '0;
        e_busy = 1'b0; e_done = 1'b0; m_prev = 1'b0; m_launch = 1'b0;
        forever begin
            m_tick(k);
            if (!k && m_launch) m_run();
        end
    end

    // ---------------- engine responders ----------------
    int            dly [NE];
    int            tmr [NE];
    logic [NE-1:0] eng_prev;

    initial begin
        eng_finish = '0;
        eng_prev   = '0;
        for (int i = 0; i < NE; i++) tmr[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NE; i++) begin
                eng_finish[i] = 1'b0;
                if (eng_bist_start[i] && !eng_prev[i]) tmr[i] = dly[i];
                else if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) eng_finish[i] = 1'b1;
                end
            end
            eng_prev = eng_bist_start;
        end
    end

    // ---------------- compare / monitor ----------------
    int            n_vec, n_err, cyc, done_cnt, done_cyc, t_rise1, t_to1;
    int            st_hi [NE];
    int            starts [$];
    logic [NE-1:0] mon_prev;
    logic          mon_to1, chk_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
        cyc++;
        for (int i = 0; i < NE; i++) begin
            if (eng_bist_start[i] === 1'b1 && mon_prev[i] !== 1'b1) begin
                starts.push_back(i);
                if (i == 1) t_rise1 = cyc;
            end
            if (eng_bist_start[i] === 1'b1) st_hi[i]++;
        end
        if (sched_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (timeout_flags[1] === 1'b1 && mon_to1 !== 1'b1) t_to1 = cyc;
        mon_prev = eng_bist_start;
        mon_to1  = timeout_flags[1];
        if (chk_en) begin
            chk("eng_bist_start", eng_bist_start, e_start);
            chk("busy", busy, e_busy);
            chk("sched_done", sched_done, e_done);
            chk("pass_flags", pass_flags, e_pass);
            chk("timeout_flags", timeout_flags, e_to);
            if (e_busy) chk("cur_eng", cur_eng, e_cur);
        end
        #1;
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
    endtask

    task automatic launch(input logic [NE-1:0] m);
        eng_mask = m; sched_start = 1'b1;
        nxt();
        sched_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (sched_done !== 1'b1 && n < 400) begin nxt(); n++; end
        chk(nm, sched_done, 1'b1);
    endtask

    task automatic chk_order(input string nm, input int base);
        chk(nm, starts.size() - base, NE);
        for (int i = 0; i < NE && base + i < starts.size(); i++)
            chk(nm, starts[base + i], i);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base, d0, c0, n;
        int hi0 [NE];
        n_vec = 0; n_err = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
        t_rise1 = 0; t_to1 = 0; mon_prev = '0; mon_to1 = 1'b0; chk_en = 1'b0;
        for (int i = 0; i < NE; i++) st_hi[i] = 0;
        reset = 1'b1; sched_start = 1'b0; abort = 1'b0; eng_mask = '0;
        set_dly(0, 0, 0, 0);
        repeat (3) nxt();
        chk("rst_start", eng_bist_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", sched_done, 0);
        chk("rst_pass", pass_flags, 0);
        chk("rst_to", timeout_flags, 0);
        chk("rst_cur", cur_eng, 0);
        reset = 1'b0; chk_en = 1'b1;
        nxt();

        // all engines finish in time
        set_dly(12, 12, 12, 12);
        base = starts.size(); d0 = done_cnt; hi0 = st_hi;
        launch(4'b1111);
        wait_done("t1_done");
        chk("t1_pass", pass_flags, 4'b1111);
        chk("t1_to", timeout_flags, 4'b0000);
        chk_order("t1_order", base);
        for (int i = 0; i < NE; i++) chk("t1_start_len", st_hi[i] - hi0[i], SL);
        repeat (3) nxt();
        chk("t1_done_cnt", done_cnt - d0, 1);

        // sparse mask, plus a relaunch edge while busy that must be ignored
        d0 = done_cnt; hi0 = st_hi;
        launch(4'b0101);
        repeat (5) nxt();
        sched_start = 1'b1; nxt(); sched_start = 1'b0;
        wait_done("t2_done");
        chk("t2_pass", pass_flags, 4'b0101);
        chk("t2_to", timeout_flags, 4'b0000);
        chk("t2_hi0", st_hi[0] - hi0[0], SL);
        chk("t2_hi1", st_hi[1] - hi0[1], 0);
        chk("t2_hi2", st_hi[2] - hi0[2], SL);
        chk("t2_hi3", st_hi[3] - hi0[3], 0);
        repeat (30) nxt();
        chk("t2_done_cnt", done_cnt - d0, 1);

        // engine 1 never finishes
        set_dly(12, 0, 12, 12);
        base = starts.size();
        launch(4'b1111);
        wait_done("t3_done");
        chk("t3_to", timeout_flags, 4'b0010);
        chk("t3_pass", pass_flags, 4'b1101);
        chk("t3_to_latency", t_to1 - t_rise1, SL + TO);
        chk_order("t3_order", base);
        repeat (3) nxt();

        // finish in the last watchdog cycle passes; one cycle later times out
        set_dly(SL + TO - 1, 0, 0, 0);
        launch(4'b0001);
        wait_done("t4a_done");
        chk("t4a_pass", pass_flags, 4'b0001);
        chk("t4a_to", timeout_flags, 4'b0000);
        repeat (3) nxt();
        set_dly(SL + TO, 0, 0, 0);
        launch(4'b0001);
        wait_done("t4b_done");
        chk("t4b_pass", pass_flags, 4'b0000);
        chk("t4b_to", timeout_flags, 4'b0001);
        repeat (5) nxt();

        // abort during engine 2 wait, then relaunch
        set_dly(12, 12, 0, 0);
        d0 = done_cnt;
        launch(4'b1111);
        n = 0;
        while (eng_bist_start[2] !== 1'b1 && n < 300) begin nxt(); n++; end
        chk("t5_eng2_started", eng_bist_start[2], 1'b1);
        repeat (4) nxt();
        abort = 1'b1; nxt(); abort = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_pass_kept", pass_flags, 4'b0011);
        chk("t5_start", eng_bist_start, 0);
        repeat (5) nxt();
        chk("t5_no_done", done_cnt - d0, 0);
        set_dly(12, 12, 12, 12);
        base = starts.size();
        launch(4'b1111);
        chk("t5_clr_pass", pass_flags, 0);
        chk("t5_cur0", cur_eng, 0);
        wait_done("t5_done");
        chk("t5_pass", pass_flags, 4'b1111);
        chk_order("t5_order", base);
        repeat (3) nxt();

        // reset during START
        launch(4'b1111);
        n = 0;
        while (eng_bist_start[0] !== 1'b1 && n < 50) begin nxt(); n++; end
        chk("t6_in_start", eng_bist_start[0], 1'b1);
        reset = 1'b1; nxt(); reset = 1'b0;
        chk("t6_rst_start", eng_bist_start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", sched_done, 0);
        chk("t6_rst_pass", pass_flags, 0);
        chk("t6_rst_to", timeout_flags, 0);
        chk("t6_rst_cur", cur_eng, 0);
        repeat (16) nxt();

        // sched_start held high through DONE gives one run only
        set_dly(5, 5, 5, 5);
        d0 = done_cnt;
        eng_mask = 4'b0011; sched_start = 1'b1;
        nxt();
        wait_done("t6_hold_done");
        repeat (10) nxt();
        chk("t6_hold_cnt", done_cnt - d0, 1);
        chk("t6_hold_busy", busy, 1'b0);
        chk("t6_hold_pass", pass_flags, 4'b0011);
        sched_start = 1'b0;
        repeat (2) nxt();

        // empty mask: done in the (NUM_ENG+2)-th cycle counting the launch cycle
        c0 = cyc;
        launch(4'b0000);
        wait_done("t6_empty_done");
        chk("t6_empty_lat", done_cyc - c0 + 1, NE + 2);
        chk("t6_empty_pass", pass_flags, 0);
        chk("t6_empty_to", timeout_flags, 0);
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
